// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller that feeds the jacaranda-8 core's
// int_req / int_en / int_vec inputs.
//
// Rising edges on the src inputs set pending bits. Each pending bit is gated
// by its source mask. The lowest-numbered eligible source wins and gets a
// single-cycle int_req pulse that carries its vector. No further request is
// issued until the core signals its ISR return on isr_ret.
//
// Register map (addr):
//   0 EN       RW  int_en: bit0 global enable, bits[NUM_SRC:1] source masks
//   1 PENDING  R / write-1-to-clear
//   2 VEC_BASE RW  base of the vector table
//   3 STATUS   RO  {in_service, 4'b0, active_id[2:0]}
//
// Optional feature: define INT_CTRL_SYNC_EN to pass src through a 2-flop
// synchronizer before edge detection. This adds 2 cycles of latency. When it
// is undefined, src must already be synchronous to clock.
module int_ctrl #(
  parameter int         NUM_SRC   = 4,
  parameter int         VEC_SHIFT = 2,
  parameter logic [7:0] VEC_RST   = 8'hE0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               isr_ret,
  input  logic [1:0]         addr,
  input  logic [7:0]         w_data,
  input  logic               w_en,
  output logic [7:0]         r_data,
  output logic               int_req,
  output logic [7:0]         int_en,
  output logic [7:0]         int_vec
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]         en;
  logic [7:0]         vec_base;
  logic [7:0]         vec;
  logic [7:0]         vec_nxt;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ack;
  logic [2:0]         active_id;
  logic [2:0]         winner;
  logic               take;
  logic               in_service;

`ifdef INT_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync_p0;
  logic [NUM_SRC-1:0] sync_p1;

  // Two-flop synchronizer for asynchronous sources
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= src;
      sync_p1 <= sync_p0;
    end
  end

  assign src_s = sync_p1;
`else
  assign src_s = src;
`endif

  // Previous-cycle copy of the sources for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q <= '0;
    end else begin
      src_q <= src_s;
    end
  end

  assign rise     = src_s & ~src_q;
  assign eligible = pending & en[NUM_SRC:1];

  // Priority pick: the lowest set index wins, so scan downward and let the
  // last hit stand
  always_comb begin
    winner = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = 3'(i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and request decode; take marks the edge that accepts a winner
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    int_req   = 1'b0;
    case (state)
      IDLE: begin
        if (en[0] && (eligible != '0)) begin
          state_nxt = REQ;
          take      = 1'b1;
        end
      end
      REQ: begin
        int_req   = 1'b1;
        state_nxt = SERVICE;
      end
      SERVICE: begin
        // isr_ret is the only exit; dropping the global enable does not abort
        if (isr_ret) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign in_service = (state == SERVICE);

  // Clear sources: the auto-ack of the accepted winner plus any W1C write.
  // A rising edge in the same cycle sets the bit again, so set wins.
  always_comb begin
    ack = take ? (NUM_SRC'(1) << winner) : '0;
    w1c = (w_en && (addr == 2'd1)) ? w_data[NUM_SRC-1:0] : '0;
    pending_nxt = (pending & ~(w1c | ack)) | rise;
  end

  // Pending latch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Vector address for the winner, 8-bit wraparound
  assign vec_nxt = vec_base + (8'(winner) << VEC_SHIFT);

  // Capture the active id and its vector when the request is accepted;
  // the vector then holds until the next request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_id <= 3'd0;
      vec       <= VEC_RST;
    end else if (take) begin
      active_id <= winner;
      vec       <= vec_nxt;
    end
  end

  // Writable configuration registers (EN, VEC_BASE)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en       <= 8'h00;
      vec_base <= VEC_RST;
    end else if (w_en) begin
      case (addr)
        2'd0:    en       <= w_data;
        2'd2:    vec_base <= w_data;
        default: ;
      endcase
    end
  end

  // Combinational register read-back
  always_comb begin
    r_data = 8'h00;
    case (addr)
      2'd0:    r_data = en;
      2'd1:    r_data = 8'(pending);
      2'd2:    r_data = vec_base;
      default: r_data = {in_service, 4'b0000, active_id};
    endcase
  end

  assign int_en  = en;
  assign int_vec = vec;

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl (default build, src synchronous). The reference model
// tracks pending bits, the in-service flag, and the request/vector at the level
// of the interrupt rules, and it advances one clock at a time alongside the DUT.
module tb_int_ctrl;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] src;
  logic         isr_ret;
  logic [1:0]   addr;
  logic [7:0]   w_data;
  logic         w_en;
  logic [7:0]   r_data;
  logic         int_req;
  logic [7:0]   int_en;
  logic [7:0]   int_vec;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  logic [N-1:0] m_pend;
  logic [N-1:0] m_srcq;
  logic [7:0]   m_en;
  logic [7:0]   m_base;
  logic [7:0]   m_vec;
  logic         m_req;
  logic         m_svc;
  int           m_id;

  int_ctrl #(.NUM_SRC(N), .VEC_SHIFT(2), .VEC_RST(8'hE0)) dut (
    .clock   (clock),
    .reset   (reset),
    .src     (src),
    .isr_ret (isr_ret),
    .addr    (addr),
    .w_data  (w_data),
    .w_en    (w_en),
    .r_data  (r_data),
    .int_req (int_req),
    .int_en  (int_en),
    .int_vec (int_vec)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, pass=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_en;
      2'd1:    return 8'(m_pend);
      2'd2:    return m_base;
      default: return {m_svc, 4'b0000, 3'(m_id)};
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_srcq = '0; m_en = 8'h00; m_base = 8'hE0;
    m_vec = 8'hE0; m_req = 1'b0; m_svc = 1'b0; m_id = 0;
  endtask

  // Advance model and DUT across one rising edge using the current inputs
  task automatic step();
    logic [N-1:0] rise, clr, elig;
    logic         n_req, n_svc;
    int           n_id;
    logic [7:0]   n_vec;
    rise = src & ~m_srcq;
    clr = '0; elig = '0;
    n_req = 1'b0; n_svc = m_svc; n_id = m_id; n_vec = m_vec;
    if (m_req) begin
      n_svc = 1'b1;
    end else if (m_svc) begin
      if (isr_ret) n_svc = 1'b0;
    end else begin
      elig = m_pend & m_en[N:1];
      if (m_en[0] && elig != '0) begin
        for (int i = 0; i < N; i++) begin
          if (elig[i]) begin n_id = i; break; end
        end
        n_req = 1'b1;
        n_vec = m_base + 8'(n_id * 4);
        clr[n_id] = 1'b1;
      end
    end
    if (w_en && addr == 2'd1) clr = clr | w_data[N-1:0];
    m_pend = (m_pend & ~clr) | rise;
    m_srcq = src;
    if (w_en && addr == 2'd0) m_en = w_data;
    if (w_en && addr == 2'd2) m_base = w_data;
    m_req = n_req; m_svc = n_svc; m_id = n_id; m_vec = n_vec;
    @(posedge clock);
    #1;
    w_en = 1'b0;
    isr_ret = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; src = '0; isr_ret = 1'b0; w_en = 1'b0; addr = 2'd0; w_data = 8'h00;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr = a; w_data = d; w_en = 1'b1;
    step();
  endtask

  task automatic wait_req(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      if (int_req === 1'b1) got = 1'b1;
    end
  endtask

  task automatic run_count(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (int_req === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++; if (int_req !== 1'b0) $display("FAIL reset_int_req: got %b expected 0", int_req); else pass_cnt++;
    total_cnt++; if (int_en !== 8'h00) $display("FAIL reset_int_en: got %h expected 00", int_en); else pass_cnt++;
    total_cnt++; if (int_vec !== 8'hE0) $display("FAIL reset_int_vec: got %h expected e0", int_vec); else pass_cnt++;
    addr = 2'd1; #1;
    total_cnt++; if (r_data !== 8'h00) $display("FAIL reset_pending: got %h expected 00", r_data); else pass_cnt++;
    addr = 2'd2; #1;
    total_cnt++; if (r_data !== 8'hE0) $display("FAIL reset_vec_base: got %h expected e0", r_data); else pass_cnt++;
    addr = 2'd3; #1;
    total_cnt++; if (r_data !== 8'h00) $display("FAIL reset_status: got %h expected 00", r_data); else pass_cnt++;
  endtask

  task automatic test_single();
    bit got;
    apply_reset();
    wr(2'd0, 8'h03);
    src = 4'b0001;
    wait_req(8, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL single_req: got %b expected 1", got); else pass_cnt++;
    total_cnt++; if (int_vec !== 8'hE0) $display("FAIL single_vec: got %h expected e0", int_vec); else pass_cnt++;
    step();
    total_cnt++; if (int_req !== 1'b0) $display("FAIL single_pulse_width: got %b expected 0", int_req); else pass_cnt++;
    addr = 2'd1; #1;
    total_cnt++; if (r_data !== 8'h00) $display("FAIL single_pending: got %h expected 00", r_data); else pass_cnt++;
    addr = 2'd3; #1;
    total_cnt++; if (r_data !== 8'h80) $display("FAIL single_status: got %h expected 80", r_data); else pass_cnt++;
    isr_ret = 1'b1;
    step();
    addr = 2'd3; #1;
    total_cnt++; if (r_data !== 8'h00) $display("FAIL single_status_after_ret: got %h expected 00", r_data); else pass_cnt++;
  endtask

  task automatic test_priority();
    bit got;
    apply_reset();
    wr(2'd0, 8'h1F);
    src = 4'b0110;
    wait_req(8, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL prio_req1: got %b expected 1", got); else pass_cnt++;
    total_cnt++; if (int_vec !== 8'hE4) $display("FAIL prio_vec1: got %h expected e4", int_vec); else pass_cnt++;
    step();
    isr_ret = 1'b1;
    step();
    wait_req(8, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL prio_req2: got %b expected 1", got); else pass_cnt++;
    total_cnt++; if (int_vec !== 8'hE8) $display("FAIL prio_vec2: got %h expected e8", int_vec); else pass_cnt++;
    step();
    isr_ret = 1'b1;
    step();
  endtask

  task automatic test_global_off();
    bit got;
    int p;
    apply_reset();
    wr(2'd0, 8'h02);
    src = 4'b0001;
    run_count(6, p);
    total_cnt++; if (p !== 0) $display("FAIL gloff_no_req: got %0d pulses expected 0", p); else pass_cnt++;
    addr = 2'd1; #1;
    total_cnt++; if (r_data !== 8'h01) $display("FAIL gloff_pending: got %h expected 01", r_data); else pass_cnt++;
    wr(2'd0, 8'h03);
    wait_req(4, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL gloff_req_after_en: got %b expected 1", got); else pass_cnt++;
    total_cnt++; if (int_vec !== 8'hE0) $display("FAIL gloff_vec: got %h expected e0", int_vec); else pass_cnt++;
  endtask

  task automatic test_service_block();
    bit got;
    int p;
    apply_reset();
    wr(2'd0, 8'h1F);
    src = 4'b0001;
    wait_req(8, got);
    step();
    src = 4'b1001;
    run_count(6, p);
    total_cnt++; if (p !== 0) $display("FAIL svc_blocked: got %0d pulses expected 0", p); else pass_cnt++;
    isr_ret = 1'b1;
    step();
    wait_req(4, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL svc_req_after_ret: got %b expected 1", got); else pass_cnt++;
    total_cnt++; if (int_vec !== 8'hEC) $display("FAIL svc_vec: got %h expected ec", int_vec); else pass_cnt++;
    step();
    isr_ret = 1'b1;
    step();
    run_count(6, p);
    total_cnt++; if (p !== 0) $display("FAIL svc_single_pulse: got %0d extra pulses expected 0", p); else pass_cnt++;
  endtask

  task automatic test_set_wins();
    apply_reset();
    step();
    src = 4'b0001;
    wr(2'd1, 8'h01);
    addr = 2'd1; #1;
    total_cnt++; if (r_data !== 8'h01) $display("FAIL setwins_pending: got %h expected 01", r_data); else pass_cnt++;
    wr(2'd1, 8'h01);
    addr = 2'd1; #1;
    total_cnt++; if (r_data !== 8'h00) $display("FAIL w1c_pending: got %h expected 00", r_data); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit got;
    int p;
    apply_reset();
    wr(2'd0, 8'h03);
    wr(2'd2, 8'h40);
    src = 4'b0001;
    wait_req(8, got);
    total_cnt++; if (int_vec !== 8'h40) $display("FAIL rstmid_vec_pre: got %h expected 40", int_vec); else pass_cnt++;
    step();
    #2;
    reset = 1'b1;
    #1;
    total_cnt++; if (int_en !== 8'h00) $display("FAIL rstmid_int_en: got %h expected 00", int_en); else pass_cnt++;
    total_cnt++; if (int_vec !== 8'hE0) $display("FAIL rstmid_int_vec: got %h expected e0", int_vec); else pass_cnt++;
    addr = 2'd3; #1;
    total_cnt++; if (r_data !== 8'h00) $display("FAIL rstmid_status: got %h expected 00", r_data); else pass_cnt++;
    reset = 1'b0;
    model_reset();
    run_count(6, p);
    total_cnt++; if (p !== 0) $display("FAIL rstmid_no_req: got %0d pulses expected 0", p); else pass_cnt++;
  endtask

  task automatic test_random();
    int k;
    int r;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, N - 1);
        src[k] = ~src[k];
      end
      isr_ret = ($urandom_range(0, 4) == 0);
      w_en = 1'b0;
      r = $urandom_range(0, 15);
      if (r == 0) begin
        addr = 2'd0; w_data = 8'($urandom); w_data[0] = ($urandom_range(0, 3) != 0); w_en = 1'b1;
      end else if (r == 1) begin
        addr = 2'd1; w_data = 8'($urandom); w_en = 1'b1;
      end else if (r == 2) begin
        addr = 2'd2; w_data = 8'($urandom); w_en = 1'b1;
      end else begin
        addr = 2'($urandom_range(0, 3));
      end
      #1;
      total_cnt++; if (r_data !== m_read(addr)) $display("FAIL rand_rdata c=%0d addr=%0d: got %h expected %h", c, addr, r_data, m_read(addr)); else pass_cnt++;
      step();
      total_cnt++; if (int_req !== m_req) $display("FAIL rand_int_req c=%0d: got %b expected %b", c, int_req, m_req); else pass_cnt++;
      total_cnt++; if (int_vec !== m_vec) $display("FAIL rand_int_vec c=%0d: got %h expected %h", c, int_vec, m_vec); else pass_cnt++;
      total_cnt++; if (int_en !== m_en) $display("FAIL rand_int_en c=%0d: got %h expected %h", c, int_en, m_en); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_global_off();
    test_service_block();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
